// File: rtl/candy_id_stage_pkg.sv
// Shared types and field-width helpers for the candy decode stage.
package candy_id_stage_pkg;

    // Two-bit format code carried in the top bits of every instruction.
    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_S = 2'b10,
        FMT_U = 2'b11
    } fmt_e;

    // Occupancy of the main (M) and skid (K) registers.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Opcode field width of each format.
    localparam int R_OP_W = 6;
    localparam int I_OP_W = 4;
    localparam int S_OP_W = 4;
    localparam int U_OP_W = 3;

    // Immediate width shared by I and S: whatever remains below op, rs1 and rd/rs2.
    function automatic int imm_is_w(input int inst_w, input int reg_aw);
        return inst_w - 2 - I_OP_W - 2 * reg_aw;
    endfunction

    // U immediate width: whatever remains below op and rd.
    function automatic int imm_u_w(input int inst_w, input int reg_aw);
        return inst_w - 2 - U_OP_W - reg_aw;
    endfunction

    // Bits left unused at the bottom of an R word; negative means the fields do not fit.
    function automatic int r_spare_w(input int inst_w, input int reg_aw);
        return inst_w - 2 - R_OP_W - 3 * reg_aw;
    endfunction

endpackage

// File: rtl/candy_id_decode.sv
// Pure combinational instruction splitter: inst -> format, op, registers, immediate, enables.
module candy_id_decode
    import candy_id_stage_pkg::*;
#(
    parameter int INST_W  = 24,
    parameter int REG_AW  = 4,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32,
    parameter int N_R_OPS = 32
) (
    input  logic [INST_W-1:0] inst,
    output logic [1:0]        fmt,
    output logic [OP_W-1:0]   op,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   imm,
    output logic              re1,
    output logic              re2,
    output logic              we,
    output logic              illegal
);

    localparam int T        = INST_W - 3;
    localparam int IMM_IS_W = imm_is_w(INST_W, REG_AW);
    localparam int IMM_U_W  = imm_u_w(INST_W, REG_AW);

    // Reject parameter sets whose fields cannot be laid out without overlap.
    if (IMM_IS_W < 1 || IMM_IS_W > XLEN) begin : g_bad_imm_is
        $error("candy_id_decode: I/S immediate width %0d outside 1..XLEN", IMM_IS_W);
    end
    if (IMM_U_W < 1 || IMM_U_W > XLEN) begin : g_bad_imm_u
        $error("candy_id_decode: U immediate width %0d outside 1..XLEN", IMM_U_W);
    end
    if (r_spare_w(INST_W, REG_AW) < 0) begin : g_bad_r
        $error("candy_id_decode: R fields do not fit in INST_W");
    end
    if (OP_W < R_OP_W) begin : g_bad_op_w
        $error("candy_id_decode: OP_W must hold the widest op field");
    end

    fmt_e                fmt_code;
    logic [R_OP_W-1:0]   r_op;
    logic [REG_AW-1:0]   r_rs1, r_rs2, r_rd;
    logic [I_OP_W-1:0]   is_op;
    logic [REG_AW-1:0]   is_rs1, is_reg2;
    logic [IMM_IS_W-1:0] is_imm;
    logic [U_OP_W-1:0]   u_op;
    logic [REG_AW-1:0]   u_rd;
    logic [IMM_U_W-1:0]  u_imm;
    logic                r_illegal;

    assign fmt_code  = fmt_e'(inst[INST_W-1 -: 2]);
    assign r_op      = inst[T -: R_OP_W];
    assign r_rs1     = inst[T-R_OP_W -: REG_AW];
    assign r_rs2     = inst[T-R_OP_W-REG_AW -: REG_AW];
    assign r_rd      = inst[T-R_OP_W-2*REG_AW -: REG_AW];
    assign is_op     = inst[T -: I_OP_W];
    assign is_rs1    = inst[T-I_OP_W -: REG_AW];
    assign is_reg2   = inst[T-I_OP_W-REG_AW -: REG_AW];
    assign is_imm    = inst[IMM_IS_W-1:0];
    assign u_op      = inst[T -: U_OP_W];
    assign u_rd      = inst[T-U_OP_W -: REG_AW];
    assign u_imm     = inst[IMM_U_W-1:0];
    assign r_illegal = int'(r_op) >= N_R_OPS;

    // Route the per-format fields onto the common bundle.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        fmt     = fmt_code;
        op      = '0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        imm     = '0;
        re1     = 1'b0;
        re2     = 1'b0;
        we      = 1'b0;
        illegal = 1'b0;
        case (fmt_code)
            FMT_R: begin
                op  = OP_W'(r_op);
                rs1 = r_rs1;
                rs2 = r_rs2;
                rd  = r_rd;
                if (r_illegal) begin
                    illegal = 1'b1;
                end else begin
                    re1 = 1'b1;
                    re2 = 1'b1;
                    we  = (r_rd != '0);
                end
            end
            FMT_I: begin
                op  = OP_W'(is_op);
                rs1 = is_rs1;
                rd  = is_reg2;
                imm = XLEN'($signed(is_imm));
                re1 = 1'b1;
                we  = (is_reg2 != '0);
            end
            FMT_S: begin
                op  = OP_W'(is_op);
                rs1 = is_rs1;
                rs2 = is_reg2;
                imm = XLEN'($signed(is_imm));
                re1 = 1'b1;
                re2 = 1'b1;
            end
            FMT_U: begin
                op  = OP_W'(u_op);
                rd  = u_rd;
                imm = XLEN'(u_imm);
                we  = (u_rd != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/candy_id_stage.sv
// Decode pipeline stage: decodes on entry, holds results in a 2-deep skid buffer (M then K).
module candy_id_stage
    import candy_id_stage_pkg::*;
#(
    parameter int INST_W  = 24,
    parameter int REG_AW  = 4,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32,
    parameter int N_R_OPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        fmt,
    output logic [OP_W-1:0]   op,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   imm,
    output logic              re1,
    output logic              re2,
    output logic              we,
    output logic              illegal
);

    typedef struct packed {
        logic [1:0]        fmt;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic              re1;
        logic              re2;
        logic              we;
        logic              illegal;
    } bundle_t;

    bundle_t dec, m_q, k_q;
    state_e  state;
    logic    in_ready_q;
    logic    accept, drain;

    candy_id_decode #(
        .INST_W (INST_W),
        .REG_AW (REG_AW),
        .OP_W   (OP_W),
        .XLEN   (XLEN),
        .N_R_OPS(N_R_OPS)
    ) u_decode (
        .inst   (inst),
        .fmt    (dec.fmt),
        .op     (dec.op),
        .rs1    (dec.rs1),
        .rs2    (dec.rs2),
        .rd     (dec.rd),
        .imm    (dec.imm),
        .re1    (dec.re1),
        .re2    (dec.re2),
        .we     (dec.we),
        .illegal(dec.illegal)
    );

    // in_ready is registered, so it already excludes the FULL state here.
    assign accept = in_valid && in_ready_q;
    assign drain  = (state != ST_EMPTY) && out_ready;

    // Buffer FSM: occupancy, main register and the registered in_ready.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values, whatever the statement order.
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
            m_q        <= '0;
        end else if (flush) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state <= ST_BUSY;
                        m_q   <= dec;
                    end
                end
                ST_BUSY: begin
                    in_ready_q <= 1'b1;
                    if (accept && drain) begin
                        m_q <= dec;
                    end else if (accept) begin
                        state      <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    in_ready_q <= 1'b0;
                    if (drain) begin
                        state      <= ST_BUSY;
                        in_ready_q <= 1'b1;
                        m_q        <= k_q;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Skid register captures the word accepted while M is stalled.
    always_ff @(posedge clk) begin
        // NOTE: K is never visible on the outputs and is only read when marked occupied, so it carries no reset.
        if (state == ST_BUSY && accept && !drain) begin
            k_q <= dec;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign fmt       = m_q.fmt;
    assign op        = m_q.op;
    assign rs1       = m_q.rs1;
    assign rs2       = m_q.rs2;
    assign rd        = m_q.rd;
    assign imm       = m_q.imm;
    assign re1       = m_q.re1;
    assign re2       = m_q.re2;
    assign we        = m_q.we;
    assign illegal   = m_q.illegal;

endmodule

// File: tb/tb_candy_id_stage.sv
// Scoreboard bench for candy_id_stage: directed decode cases, backpressure, flush, reset, random traffic.
module tb_candy_id_stage;

    localparam int INST_W  = 24;
    localparam int REG_AW  = 4;
    localparam int OP_W    = 6;
    localparam int XLEN    = 32;
    localparam int N_R_OPS = 32;

    typedef struct packed {
        logic [1:0]        fmt;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic              re1;
        logic              re2;
        logic              we;
        logic              illegal;
    } bundle_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [INST_W-1:0] inst = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        fmt;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm;
    logic              re1, re2, we, illegal;

    int      n_checks = 0;
    int      n_pass   = 0;
    bundle_t exp_q[$];

    always #5 clk = ~clk;

    candy_id_stage #(
        .INST_W (INST_W),
        .REG_AW (REG_AW),
        .OP_W   (OP_W),
        .XLEN   (XLEN),
        .N_R_OPS(N_R_OPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fmt      (fmt),
        .op       (op),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm      (imm),
        .re1      (re1),
        .re2      (re2),
        .we       (we),
        .illegal  (illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bundle_t actual();
        bundle_t b;
        b.fmt = fmt; b.op = op; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm;
        b.re1 = re1; b.re2 = re2; b.we = we; b.illegal = illegal;
        return b;
    endfunction

    // Unsigned field of n bits starting at bit lo.
    function automatic longint bits(input logic [INST_W-1:0] w, input int lo, input int n);
        return (longint'(w) >> lo) & ((longint'(1) << n) - 1);
    endfunction

    // Reference decoder: walks fields from the top down; the immediate is whatever is left.
    function automatic bundle_t model(input logic [INST_W-1:0] w);
        bundle_t b = '0;
        int      pos = INST_W - 2;
        int      f = int'(bits(w, INST_W - 2, 2));
        longint  v, second;
        b.fmt = 2'(f);
        if (f == 0) begin
            pos -= 6;      v = bits(w, pos, 6); b.op = OP_W'(v);
            pos -= REG_AW; b.rs1 = REG_AW'(bits(w, pos, REG_AW));
            pos -= REG_AW; b.rs2 = REG_AW'(bits(w, pos, REG_AW));
            pos -= REG_AW; b.rd  = REG_AW'(bits(w, pos, REG_AW));
            if (v >= N_R_OPS) b.illegal = 1'b1;
            else begin b.re1 = 1'b1; b.re2 = 1'b1; b.we = (b.rd != 0); end
        end else if (f == 1 || f == 2) begin
            pos -= 4;      b.op = OP_W'(bits(w, pos, 4));
            pos -= REG_AW; b.rs1 = REG_AW'(bits(w, pos, REG_AW));
            pos -= REG_AW; second = bits(w, pos, REG_AW);
            v = bits(w, 0, pos);
            if (v >= (longint'(1) << (pos - 1))) v -= (longint'(1) << pos);
            b.imm = XLEN'(v);
            b.re1 = 1'b1;
            if (f == 1) begin b.rd = REG_AW'(second); b.we = (second != 0); end
            else begin b.rs2 = REG_AW'(second); b.re2 = 1'b1; end
        end else begin
            pos -= 3;      b.op = OP_W'(bits(w, pos, 3));
            pos -= REG_AW; b.rd = REG_AW'(bits(w, pos, REG_AW));
            b.imm = XLEN'(bits(w, 0, pos));
            b.we  = (b.rd != 0);
        end
        return b;
    endfunction

    // Monitor: occupancy-derived handshake checks, hold stability, in-order data on every drain.
    initial begin
        bundle_t cur, prev_out;
        logic    last_rst = 1'b1;
        logic    prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            cur = actual();
            if (last_rst) begin
                check("reset_outputs", {cur, out_valid, in_ready}, '0);
            end else begin
                check("out_valid", out_valid, exp_q.size() > 0);
                check("in_ready", in_ready, exp_q.size() < 2);
                if (prev_stall) check("hold_stable", {out_valid, cur}, {1'b1, prev_out});
            end
            prev_stall = out_valid && !out_ready && !flush && !rst;
            prev_out   = cur;
            last_rst   = rst;
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) check("drain_data", cur, exp_q.pop_front());
                if (in_valid && in_ready) exp_q.push_back(model(inst));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Offer w until the stage takes it; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [INST_W-1:0] w);
        bit ok = 1'b0;
        in_valid = 1'b1;
        inst     = w;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", in_ready, 1'b1);
    endtask

    task automatic wait_idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!out_valid) break;
            @(posedge clk); #1;
        end
        check("idle_timeout", out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic directed(input string name, input logic [INST_W-1:0] w, input bundle_t exp);
        out_ready = 1'b1;
        send(w);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check(name, actual(), exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int cycles;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        directed("dec_r", 24'h031230, '{fmt: 2'd0, op: 6'd3, rs1: 4'd1, rs2: 4'd2, rd: 4'd3,
                 imm: 32'h0, re1: 1'b1, re2: 1'b1, we: 1'b1, illegal: 1'b0});
        directed("dec_i", 24'h495BFF, '{fmt: 2'd1, op: 6'd2, rs1: 4'd5, rs2: 4'd0, rd: 4'd6,
                 imm: 32'hFFFFFFFF, re1: 1'b1, re2: 1'b0, we: 1'b1, illegal: 1'b0});
        directed("dec_s", 24'h95E600, '{fmt: 2'd2, op: 6'd5, rs1: 4'd7, rs2: 4'd9, rd: 4'd0,
                 imm: 32'hFFFFFE00, re1: 1'b1, re2: 1'b1, we: 1'b0, illegal: 1'b0});
        directed("dec_u", 24'hC81234, '{fmt: 2'd3, op: 6'd1, rs1: 4'd0, rs2: 4'd0, rd: 4'd0,
                 imm: 32'h00001234, re1: 1'b0, re2: 1'b0, we: 1'b0, illegal: 1'b0});
        directed("dec_illegal", 24'h3F1230, '{fmt: 2'd0, op: 6'h3F, rs1: 4'd1, rs2: 4'd2, rd: 4'd3,
                 imm: 32'h0, re1: 1'b0, re2: 1'b0, we: 1'b0, illegal: 1'b1});
        directed("dec_r_rd0", 24'h1F1200, '{fmt: 2'd0, op: 6'h1F, rs1: 4'd1, rs2: 4'd2, rd: 4'd0,
                 imm: 32'h0, re1: 1'b1, re2: 1'b1, we: 1'b0, illegal: 1'b0});
        wait_idle();

        // Backpressure: two words fill M and K, the third waits until the consumer drains.
        out_ready = 1'b0;
        send(24'h041450);
        send(24'h4A1801);
        inst = 24'hC90077;
        @(negedge clk);
        check("bp_full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_full_hold", {in_ready, out_valid}, 2'b01);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(24'hC90077);
        wait_idle();

        // Back-to-back streaming sustains one word per cycle.
        out_ready = 1'b1;
        cycles = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            inst     = INST_W'($urandom);
            @(negedge clk);
            if (in_ready) i = i; else i--;
            cycles++;
            @(posedge clk); #1;
            if (cycles > 40) break;
        end
        check("stream_cycles", cycles, 8);
        wait_idle();

        // Flush while FULL with a word offered: everything held or offered disappears.
        out_ready = 1'b0;
        send(24'h0A2340);
        send(24'h5C3456);
        inst  = 24'hCFFFFF;
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_state", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        directed("post_flush_i", 24'h495BFF, '{fmt: 2'd1, op: 6'd2, rs1: 4'd5, rs2: 4'd0, rd: 4'd6,
                 imm: 32'hFFFFFFFF, re1: 1'b1, re2: 1'b0, we: 1'b1, illegal: 1'b0});
        wait_idle();

        // Reset mid-stream clears every output, then decode resumes.
        out_ready = 1'b0;
        send(24'h031230);
        inst = 24'h495BFF;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", {actual(), out_valid, in_ready}, '0);
        @(posedge clk); #1;
        directed("post_reset_r", 24'h031230, '{fmt: 2'd0, op: 6'd3, rs1: 4'd1, rs2: 4'd2, rd: 4'd3,
                 imm: 32'h0, re1: 1'b1, re2: 1'b1, we: 1'b1, illegal: 1'b0});

        // Random traffic with occasional flush and reset, checked by the monitor.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            inst      = INST_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        rst   = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
